// File: rtl/cla_stream_accumulator.sv
// cla_stream_accumulator: accumulates LEN N-bit stream operands into a 2N-bit sum through two chained CLA slices.
// Optional macro SIGNED_IN_EN: sign-extended operands with two's-complement overflow detection.
module cla_stream_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 9
) (
    input  logic             PHI,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] LEN,
    input  logic             IN_VALID,
    input  logic [N-1:0]     IN_DATA,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [2*N-1:0]   OUT_SUM,
    output logic             OUT_OVF,
    output logic             BUSY
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [2*N-1:0]   acc, addend, sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf, add_ovf, beat;
    logic [N:0]       lo, hi;

    // Kogge-Stone prefix over generate/propagate; returns {cout, sum}
    function automatic logic [N:0] cla_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        logic [N-1:0] p, gg, pp;
        logic [N:0]   c;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        for (int d = 1; d < N; d = d * 2)
            for (int i = N - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        c[0] = cin;
        for (int i = 0; i < N; i++)
            c[i+1] = gg[i] | (pp[i] & cin);
        return {c[N], p ^ c[N-1:0]};
    endfunction

`ifdef SIGNED_IN_EN
    assign addend  = {{N{IN_DATA[N-1]}}, IN_DATA};
    assign add_ovf = (acc[2*N-1] == addend[2*N-1]) & (sum[2*N-1] != acc[2*N-1]);
`else
    assign addend  = {{N{1'b0}}, IN_DATA};
    assign add_ovf = hi[N];
`endif

    assign lo        = cla_add(acc[N-1:0], addend[N-1:0], 1'b0);
    assign hi        = cla_add(acc[2*N-1:N], addend[2*N-1:N], lo[N]);
    assign sum       = {hi[N-1:0], lo[N-1:0]};
    assign IN_READY  = state == ACCUM;
    assign OUT_VALID = state == HOLD;
    assign BUSY      = state != IDLE;
    assign OUT_SUM   = acc;
    assign OUT_OVF   = ovf;
    assign beat      = IN_VALID & IN_READY;

    always_ff @(posedge PHI) begin
        if (RST) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    acc   <= '0;
                    ovf   <= 1'b0;
                    cnt   <= LEN;
                    state <= (LEN == '0) ? HOLD : ACCUM;
                end
                ACCUM: if (beat) begin
                    acc   <= sum;
                    cnt   <= cnt - 1'b1;
                    ovf   <= ovf | add_ovf;
                    state <= (cnt == CNT_W'(1)) ? HOLD : ACCUM;
                end
                HOLD: if (OUT_READY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_stream_accumulator.sv
// tb_cla_stream_accumulator: scoreboard bench for cla_stream_accumulator; honours SIGNED_IN_EN when defined.
module tb_cla_stream_accumulator;
    logic        PHI = 1'b0, RST = 1'b1, START = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
    logic [8:0]  LEN = '0;
    logic [7:0]  IN_DATA = '0;
    logic        IN_READY, OUT_VALID, OUT_OVF, BUSY;
    logic [15:0] OUT_SUM;

    int          n_chk = 0, n_fail = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    logic [7:0]  stim[$];

    cla_stream_accumulator #(.N(8), .CNT_W(9)) dut (
        .PHI(PHI), .RST(RST), .START(START), .LEN(LEN),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_SUM(OUT_SUM), .OUT_OVF(OUT_OVF), .BUSY(BUSY)
    );

    always #5 PHI = ~PHI;

    // reference add: {sticky ovf, 16-bit sum}
    function automatic logic [16:0] model_step(input logic [16:0] st, input logic [7:0] d);
        int   r;
        logic o;
`ifdef SIGNED_IN_EN
        r = int'($signed(st[15:0])) + int'($signed(d));
        o = (r > 32767) || (r < -32768);
`else
        r = int'(st[15:0]) + int'(d);
        o = r > 65535;
`endif
        return {st[16] | o, 16'(r)};
    endfunction

    task automatic push_expected();
        logic [16:0] st = '0;
        foreach (stim[i]) st = model_step(st, stim[i]);
        exp_q.push_back(st);
    endtask

    task automatic tick();
        @(posedge PHI);
        #1;
    endtask

    task automatic start_job(input int len);
        START = 1'b1;
        LEN   = 9'(len);
        tick();
        START = 1'b0;
    endtask

    task automatic feed();
        foreach (stim[i]) begin
            IN_VALID = 1'b1;
            IN_DATA  = stim[i];
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic handshake();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        RST = 1'b0;
        n_chk++;
        if ({IN_READY, OUT_VALID, BUSY, OUT_OVF, OUT_SUM} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {IN_READY, OUT_VALID, BUSY, OUT_OVF, OUT_SUM});
        end
    endtask

    task automatic test_back_to_back();
        stim = '{8'hFF, 8'hFF, 8'hFF};
        push_expected();
        start_job(3);
        feed();
        n_chk++;
        if (OUT_VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_latency: out_valid=%b want 1", OUT_VALID);
        end
        exp_v = exp_q.pop_front();
        n_chk++;
        if ({OUT_OVF, OUT_SUM} !== exp_v || exp_v !== 17'h002FD) begin
            n_fail++;
            $display("FAIL b2b_sum: got ovf=%b sum=%h want %h", OUT_OVF, OUT_SUM, exp_v);
        end
        handshake();
        n_chk++;
        if ({BUSY, OUT_VALID} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b out_valid=%b want 0 0", BUSY, OUT_VALID);
        end
    endtask

    task automatic test_len_zero();
        stim = {};
        push_expected();
        start_job(0);
        n_chk++;
        if ({OUT_VALID, IN_READY} !== 2'b10) begin
            n_fail++;
            $display("FAIL len0_flags: out_valid=%b in_ready=%b want 1 0", OUT_VALID, IN_READY);
        end
        exp_v = exp_q.pop_front();
        n_chk++;
        if ({OUT_OVF, OUT_SUM} !== exp_v) begin
            n_fail++;
            $display("FAIL len0_sum: got ovf=%b sum=%h want %h", OUT_OVF, OUT_SUM, exp_v);
        end
        handshake();
    endtask

    task automatic test_gaps();
        logic [15:0] run = '0;
        stim = '{8'd1, 8'd2, 8'd3, 8'd4};
        push_expected();
        start_job(4);
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = stim[i];
            tick();
            IN_VALID = 1'b0;
            run += 16'(stim[i]);
            if (i < 3)
                repeat (2) begin
                    tick();
                    n_chk++;
                    if ({IN_READY, OUT_SUM} !== {1'b1, run}) begin
                        n_fail++;
                        $display("FAIL gap_hold: in_ready=%b sum=%h want 1 %h", IN_READY, OUT_SUM, run);
                    end
                end
        end
        IN_VALID = 1'b1;
        IN_DATA  = 8'h55;
        n_chk++;
        if ({OUT_VALID, IN_READY} !== 2'b10) begin
            n_fail++;
            $display("FAIL gap_done: out_valid=%b in_ready=%b want 1 0", OUT_VALID, IN_READY);
        end
        tick();
        IN_VALID = 1'b0;
        exp_v = exp_q.pop_front();
        n_chk++;
        if ({OUT_OVF, OUT_SUM} !== exp_v || exp_v !== 17'h0000A) begin
            n_fail++;
            $display("FAIL gap_sum: got ovf=%b sum=%h want %h", OUT_OVF, OUT_SUM, exp_v);
        end
        handshake();
    endtask

    task automatic test_wrap();
        logic [16:0] want;
`ifdef SIGNED_IN_EN
        stim = '{8'h80, 8'hFF};
        want = 17'h0FF7F;
`else
        stim = {};
        repeat (258) stim.push_back(8'hFF);
        want = 17'h100FE;
`endif
        push_expected();
        start_job(stim.size());
        feed();
        exp_v = exp_q.pop_front();
        n_chk++;
        if ({OUT_VALID, OUT_OVF, OUT_SUM} !== {1'b1, exp_v} || exp_v !== want) begin
            n_fail++;
            $display("FAIL wrap_sum: got v=%b ovf=%b sum=%h want v=1 %h", OUT_VALID, OUT_OVF, OUT_SUM, want);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        stim = '{8'h05, 8'h06};
        push_expected();
        start_job(2);
        feed();
        exp_v = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            START = i[0];
            LEN   = 9'd7;
            tick();
            n_chk++;
            if ({OUT_VALID, OUT_OVF, OUT_SUM} !== {1'b1, exp_v}) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b ovf=%b sum=%h want v=1 %h", OUT_VALID, OUT_OVF, OUT_SUM, exp_v);
            end
        end
        START = 1'b0;
        handshake();
        n_chk++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: busy=%b want 0", BUSY);
        end
    endtask

    task automatic test_reset_mid();
        stim = '{8'h10, 8'h20};
        start_job(5);
        feed();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_chk++;
        if ({IN_READY, OUT_VALID, BUSY, OUT_OVF, OUT_SUM} !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0", {IN_READY, OUT_VALID, BUSY, OUT_OVF, OUT_SUM});
        end
        stim = '{8'h07};
        push_expected();
        start_job(1);
        feed();
        exp_v = exp_q.pop_front();
        n_chk++;
        if ({OUT_VALID, OUT_OVF, OUT_SUM} !== {1'b1, exp_v} || exp_v !== 17'h00007) begin
            n_fail++;
            $display("FAIL midreset_next: got v=%b ovf=%b sum=%h want v=1 %h", OUT_VALID, OUT_OVF, OUT_SUM, exp_v);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_len_zero();
        test_gaps();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
